// File: rtl/gpu_trace_pkg.sv
// gpu_trace_pkg: shared types for the gpu_core execution-trace buffer.
// Holds the capture FSM state encoding, the packed trace entry layout at
// default widths, and the entry width calculation used by the top level.
package gpu_trace_pkg;

   localparam int PC_W_DEF   = 8;
   localparam int OP_W_DEF   = 4;
   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 3;
   localparam int TS_W_DEF   = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      POST    = 2'd2,
      READOUT = 2'd3
   } trace_state_e;

   // Field order matches out_data, MSB first.
   typedef struct packed {
      logic [TS_W_DEF-1:0]   ts;
      logic [PC_W_DEF-1:0]   pc;
      logic [OP_W_DEF-1:0]   opcode;
      logic                  wb_en;
      logic [REG_AW_DEF-1:0] wb_addr;
      logic [DATA_W_DEF-1:0] wb_data;
   } trace_entry_t;

   function automatic int entry_width(input int pc_w, input int op_w,
                                      input int data_w, input int reg_aw,
                                      input int ts_w);
      return ts_w + pc_w + op_w + 1 + reg_aw + data_w;
   endfunction

endpackage

// File: rtl/gpu_trace_ram.sv
// gpu_trace_ram: DEPTH x ENTRY_W trace storage with one synchronous write
// port and one asynchronous read port, so readout data is visible in the
// same cycle the read pointer moves.
module gpu_trace_ram #(
   parameter int DEPTH   = 16,
   parameter int ENTRY_W = 64,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [AW-1:0]      waddr_i,
   input  logic [ENTRY_W-1:0] wdata_i,
   input  logic [AW-1:0]      raddr_i,
   output logic [ENTRY_W-1:0] rdata_o
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   // Capture write; contents are never reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gpu_trace_buffer.sv
// gpu_trace_buffer: records retired gpu_core instructions into a circular
// buffer, freezes after a trigger plus a programmable post-trigger window,
// then streams the trace oldest-first over a valid/ready port.
// Optional build macro GPU_TRACE_FILTER_EN: when defined only retires that
// write back to register filter_addr are captured.
module gpu_trace_buffer
   import gpu_trace_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int OP_W   = 4,
   parameter int DATA_W = 32,
   parameter int REG_AW = 3,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       retire_valid,
   input  logic [PC_W-1:0]            pc,
   input  logic [OP_W-1:0]            opcode,
   input  logic                       wb_en,
   input  logic [REG_AW-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic                       arm,
   input  logic                       abort,
   input  logic                       trig_ext,
   input  logic                       trig_pc_en,
   input  logic [PC_W-1:0]            trig_pc,
   input  logic [$clog2(DEPTH+1)-1:0] post_len,
   input  logic [REG_AW-1:0]          filter_addr,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [entry_width(PC_W, OP_W, DATA_W, REG_AW, TS_W)-1:0] out_data,
   output logic                       out_last,
   output logic                       out_trig
);

   localparam int ENTRY_W = entry_width(PC_W, OP_W, DATA_W, REG_AW, TS_W);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   trace_state_e     state_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, trig_idx_q;
   logic [CNT_W-1:0] count_q, post_cnt_q, rd_left_q;
   logic             trig_vld_q, overflow_q, busy_q, done_q, out_valid_q;
   logic [TS_W-1:0]  ts_q;

   logic             cq, trig, wr_en, hs, go_ro;
   logic [PTR_W-1:0] wr_ptr_after;
   logic [CNT_W-1:0] count_after;
   logic [ENTRY_W-1:0] wr_data, rd_data;

`ifdef GPU_TRACE_FILTER_EN
   assign cq = retire_valid && wb_en && (wb_addr == filter_addr);
`else
   logic unused_filter;
   assign unused_filter = ^filter_addr;
   assign cq = retire_valid;
`endif

   assign trig  = trig_ext || (trig_pc_en && cq && (pc == trig_pc));
   assign wr_en = cq && !abort && ((state_q == ARMED) || (state_q == POST));
   assign hs    = out_valid_q && out_ready;

   // Pointer and occupancy as they stand after this cycle's write (if any).
   assign wr_ptr_after = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
   assign count_after  = (wr_en && (count_q != DEPTH_C)) ? (count_q + CNT_W'(1)) : count_q;

   // The capture window closes either on a zero-length post window or on the
   // write that drains the post counter.
   assign go_ro = ((state_q == ARMED) && trig && (post_len == '0)) ||
                  ((state_q == POST) && wr_en && (post_cnt_q == CNT_W'(1)));

   assign wr_data = {ts_q, pc, opcode, wb_en, wb_addr, wb_data};

   gpu_trace_ram #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   // Capture/readout FSM with timestamp and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         trig_idx_q  <= '0;
         count_q     <= '0;
         post_cnt_q  <= '0;
         rd_left_q   <= '0;
         trig_vld_q  <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         ts_q        <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (abort) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (arm) begin
                     state_q    <= ARMED;
                     busy_q     <= 1'b1;
                     wr_ptr_q   <= '0;
                     count_q    <= '0;
                     overflow_q <= 1'b0;
                     trig_vld_q <= 1'b0;
                  end
               end
               ARMED: begin
                  if (wr_en) begin
                     wr_ptr_q <= wr_ptr_after;
                     count_q  <= count_after;
                     if (count_q == DEPTH_C) overflow_q <= 1'b1;
                  end
                  if (trig) begin
                     trig_idx_q <= cq ? wr_ptr_q : (wr_ptr_q - PTR_W'(1));
                     trig_vld_q <= (count_after != '0);
                     post_cnt_q <= post_len;
                     if (post_len != '0) state_q <= POST;
                  end
               end
               POST: begin
                  if (wr_en) begin
                     wr_ptr_q   <= wr_ptr_after;
                     count_q    <= count_after;
                     post_cnt_q <= post_cnt_q - CNT_W'(1);
                     if (count_q == DEPTH_C) overflow_q <= 1'b1;
                     // A long post window can lap the trigger entry.
                     if (wr_ptr_q == trig_idx_q) trig_vld_q <= 1'b0;
                  end
               end
               READOUT: begin
                  if (hs) begin
                     rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                     rd_left_q <= rd_left_q - CNT_W'(1);
                     if (rd_left_q == CNT_W'(1)) begin
                        state_q     <= IDLE;
                        done_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase

            if (go_ro) begin
               busy_q <= 1'b0;
               if (count_after == '0) begin
                  state_q <= IDLE;
               end else begin
                  state_q     <= READOUT;
                  done_q      <= 1'b1;
                  out_valid_q <= 1'b1;
                  rd_ptr_q    <= (count_after == DEPTH_C) ? wr_ptr_after : '0;
                  rd_left_q   <= count_after;
               end
            end
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_valid_q ? rd_data : '0;
   assign out_last  = out_valid_q && (rd_left_q == CNT_W'(1));
   assign out_trig  = out_valid_q && trig_vld_q && (rd_ptr_q == trig_idx_q);

endmodule

// File: tb/tb_gpu_trace_buffer.sv
// tb_gpu_trace_buffer: directed bench for gpu_trace_buffer with a
// scoreboard queue of expected readout entries and a decoupled monitor.
module tb_gpu_trace_buffer;
   import gpu_trace_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        retire_valid = 1'b0;
   logic [7:0]  pc = '0;
   logic [3:0]  opcode = '0;
   logic        wb_en = 1'b0;
   logic [2:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic        trig_ext = 1'b0;
   logic        trig_pc_en = 1'b0;
   logic [7:0]  trig_pc = '0;
   logic [4:0]  post_len = '0;
   logic [2:0]  filter_addr = '0;
   logic        busy, done, overflow, out_valid, out_last, out_trig;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;

   typedef struct {
      logic [7:0]  pc;
      logic [3:0]  op;
      logic [31:0] d;
      logic        trig;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   gpu_trace_buffer dut (
      .clk(clk), .rst(rst), .retire_valid(retire_valid), .pc(pc),
      .opcode(opcode), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .arm(arm), .abort(abort), .trig_ext(trig_ext), .trig_pc_en(trig_pc_en),
      .trig_pc(trig_pc), .post_len(post_len), .filter_addr(filter_addr),
      .busy(busy), .done(done), .overflow(overflow), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .out_trig(out_trig)
   );

   always #5 clk = ~clk;

   // Monitor: pops the scoreboard on every accepted entry and checks hold.
   logic         stall_q = 1'b0;
   logic [63:0]  held = '0;
   trace_entry_t e;
   exp_t         ex;
   always @(negedge clk) begin
      e = trace_entry_t'(out_data);
      if (out_valid && stall_q) begin
         checks++;
         if (out_data !== held) begin
            failures++;
            $display("FAIL hold_stable got=%h want=%h", out_data, held);
         end
      end
      if (out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_entry got pc=%h trig=%b last=%b want none", e.pc, out_trig, out_last);
         end else begin
            ex = sb.pop_front();
            if (e.pc !== ex.pc || e.opcode !== ex.op || e.wb_data !== ex.d ||
                out_trig !== ex.trig || out_last !== ex.last) begin
               failures++;
               $display("FAIL entry got pc=%h op=%h d=%h trig=%b last=%b want pc=%h op=%h d=%h trig=%b last=%b",
                        e.pc, e.opcode, e.wb_data, out_trig, out_last, ex.pc, ex.op, ex.d, ex.trig, ex.last);
            end
         end
      end
      stall_q = out_valid && !out_ready;
      held    = out_data;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic push(input logic [7:0] p, input logic [31:0] d, input logic t, input logic l);
      exp_t x;
      x.pc = p; x.op = p[3:0]; x.d = d; x.trig = t; x.last = l;
      sb.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic retire(input logic [7:0] p, input logic [2:0] wa, input logic [31:0] wd, input logic te);
      retire_valid = 1'b1; pc = p; opcode = p[3:0]; wb_en = 1'b1;
      wb_addr = wa; wb_data = wd; trig_ext = te;
      tick();
      retire_valid = 1'b0; wb_en = 1'b0; trig_ext = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || done || busy) && n < 300) begin
         tick(); n++;
      end
      checks++;
      if (n >= 300) begin
         failures++;
         $display("FAIL %s_timeout got pending=%0d done=%b want drained", name, sb.size(), done);
      end
      sb.delete();
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, 64'(busy), 0);
      chk({name, "_done"}, 64'(done), 0);
      chk({name, "_ovf"}, 64'(overflow), 0);
      chk({name, "_valid"}, 64'(out_valid), 0);
      chk({name, "_data"}, out_data, 0);
      chk({name, "_last"}, 64'(out_last), 0);
      chk({name, "_trig"}, 64'(out_trig), 0);
   endtask

   initial begin
      logic seen;
      logic rdy_seq [6];
      rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      tick(); tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      // Basic capture with PC-match trigger and post window of 2.
      for (int i = 1; i <= 5; i++) push(8'(i), 32'(i * 17), i == 3, i == 5);
      trig_pc_en = 1'b1; trig_pc = 8'd3; post_len = 5'd2;
      do_arm();
      chk("basic_busy", 64'(busy), 1);
      for (int i = 1; i <= 5; i++) retire(8'(i), 3'd1, 32'(i * 17), 1'b0);
      trig_pc_en = 1'b0;
      chk("basic_done", 64'(done), 1);
      wait_drain("basic");
      chk("basic_ovf", 64'(overflow), 0);

      // Wrap: 20 retires into 16 entries, external trigger on the last.
      for (int i = 4; i <= 19; i++) push(8'(i), 32'(i), i == 19, i == 19);
      post_len = 5'd0;
      do_arm();
      for (int i = 0; i <= 19; i++) retire(8'(i), 3'd2, 32'(i), i == 19);
      wait_drain("wrap");
      chk("wrap_ovf", 64'(overflow), 1);

      // Backpressure: ready pattern 1,0,0,1,1,1 over four entries.
      for (int i = 0; i < 4; i++) push(8'(32 + i), 32'(100 + i), i == 3, i == 3);
      out_ready = 1'b0;
      do_arm();
      for (int i = 0; i < 4; i++) retire(8'(32 + i), 3'd4, 32'(100 + i), i == 3);
      chk("bp_done", 64'(done), 1);
      for (int i = 0; i < 6; i++) begin
         out_ready = rdy_seq[i];
         tick();
      end
      chk("bp_idle_done", 64'(done), 0);
      chk("bp_idle_valid", 64'(out_valid), 0);
      chk("bp_sb_empty", 64'(sb.size()), 0);
      out_ready = 1'b1;
      sb.delete();

      // Abort during POST: back to IDLE, nothing streamed out.
      post_len = 5'd3;
      do_arm();
      retire(8'h30, 3'd1, 32'h30, 1'b1);
      retire(8'h31, 3'd1, 32'h31, 1'b0);
      chk("abort_in_post_busy", 64'(busy), 1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_busy", 64'(busy), 0);
      chk("abort_done", 64'(done), 0);
      seen = out_valid;
      for (int i = 0; i < 6; i++) begin
         retire(8'h32, 3'd1, 32'h32, 1'b0);
         seen |= out_valid;
      end
      chk("abort_no_valid", 64'(seen), 0);

      // arm together with trig_ext: must stay ARMED, trigger dropped.
      post_len = 5'd1;
      arm = 1'b1; trig_ext = 1'b1; tick(); arm = 1'b0; trig_ext = 1'b0;
      chk("armtrig_busy", 64'(busy), 1);
      chk("armtrig_done", 64'(done), 0);
      post_len = 5'd0;
      push(8'h40, 32'h40, 1'b0, 1'b0);
      push(8'h41, 32'h41, 1'b1, 1'b1);
      retire(8'h40, 3'd1, 32'h40, 1'b0);
      chk("armtrig_still_busy", 64'(busy), 1);
      retire(8'h41, 3'd1, 32'h41, 1'b1);
      wait_drain("armtrig");

      // External trigger with an empty buffer: straight back to IDLE.
      do_arm();
      trig_ext = 1'b1; tick(); trig_ext = 1'b0;
      chk("empty_busy", 64'(busy), 0);
      chk("empty_done", 64'(done), 0);
      chk("empty_valid", 64'(out_valid), 0);

      // rst during READOUT clears every output.
      out_ready = 1'b0;
      do_arm();
      for (int i = 0; i < 3; i++) retire(8'(80 + i), 3'd1, 32'(80 + i), i == 2);
      chk("rst_pre_done", 64'(done), 1);
      chk("rst_pre_trig", 64'(out_trig), 0);
      rst = 1'b1; tick();
      chk_all_zero("rst_mid");
      rst = 1'b0; out_ready = 1'b1;
      tick();

      // Writeback filter: regs 1,3,2,3 with data A,B,C,D, filter on reg 3.
      filter_addr = 3'd3;
`ifdef GPU_TRACE_FILTER_EN
      push(8'h61, 32'hB, 1'b0, 1'b0);
      push(8'h63, 32'hD, 1'b1, 1'b1);
`else
      push(8'h60, 32'hA, 1'b0, 1'b0);
      push(8'h61, 32'hB, 1'b0, 1'b0);
      push(8'h62, 32'hC, 1'b0, 1'b0);
      push(8'h63, 32'hD, 1'b1, 1'b1);
`endif
      do_arm();
      retire(8'h60, 3'd1, 32'hA, 1'b0);
      retire(8'h61, 3'd3, 32'hB, 1'b0);
      retire(8'h62, 3'd2, 32'hC, 1'b0);
      retire(8'h63, 3'd3, 32'hD, 1'b1);
      wait_drain("filter");

      tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gpu_trace_buffer.md
Name: gpu_trace_buffer

Overview:
Synthesizable execution-trace capture unit for gpu_core. It turns the bench-only PC/opcode/register monitoring into on-chip hardware. Each retired instruction (PC, opcode, register writeback, timestamp) is recorded into a circular buffer. A PC-match or external trigger is followed by a programmable post-trigger window, after which the trace is streamed out oldest-first over a valid/ready port for the FPGA debug path.

Parameters:
PC_W, 8, program counter width
OP_W, 4, opcode width
DATA_W, 32, register writeback data width
REG_AW, 3, register file address width (8 registers)
DEPTH, 16, trace entries; power of two, >= 2
TS_W, 16, timestamp counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
retire_valid  in  1  an instruction retires this cycle
pc  in  PC_W  PC of the retiring instruction
opcode  in  OP_W  opcode of the retiring instruction
wb_en  in  1  register writeback this cycle
wb_addr  in  REG_AW  writeback register index
wb_data  in  DATA_W  writeback value
arm  in  1  pulse: start a capture session
abort  in  1  pulse: return to IDLE from any state
trig_ext  in  1  external trigger pulse
trig_pc_en  in  1  enable PC-match trigger
trig_pc  in  PC_W  PC trigger value
post_len  in  $clog2(DEPTH+1)  entries to capture after the trigger entry
filter_addr  in  REG_AW  writeback filter register (used only with the optional feature)
busy  out  1  state is ARMED or POST
done  out  1  state is READOUT
overflow  out  1  sticky: the buffer wrapped since the last arm
out_valid  out  1  readout entry valid
out_ready  in  1  consumer accepts the entry
out_data  out  ENTRY_W  {ts, pc, opcode, wb_en, wb_addr, wb_data}; 64 bits at defaults
out_last  out  1  final entry of the trace
out_trig  out  1  the current entry is the trigger entry

Behaviour:
- Reset: state IDLE. wr_ptr, rd_ptr, count, post_cnt, trig_idx and timestamp are 0. All outputs are 0. The buffer contents are don't-care.
- Timestamp: free-running TS_W counter from reset; wraps; never stops.
- Capture-qualified cycle (cq): retire_valid=1.
- IDLE:
  - arm -> ARMED next cycle; clears wr_ptr, count and overflow.
  - Triggers are ignored in IDLE.
  - arm and trig in the same cycle: arm is taken, the trigger is dropped.
- ARMED:
  - Each cq writes an entry at wr_ptr. wr_ptr wraps mod DEPTH. count saturates at DEPTH.
  - A write while count==DEPTH overwrites the oldest entry and sets overflow.
  - Trigger = trig_ext, or (trig_pc_en and cq and pc==trig_pc).
  - On trigger: if cq, that cycle's entry is written. trig_idx latches the index of the trigger entry; for trig_ext without cq, this is the last written entry (wr_ptr-1). If count==0 at that point, no trigger entry is flagged.
  - Next state POST, with post_cnt=post_len.
  - post_len==0 -> READOUT directly.
- POST:
  - Each cq writes and decrements post_cnt. At 0 -> READOUT next cycle.
  - Further triggers are ignored.
  - post_len > DEPTH-1 may overwrite the trigger entry; out_trig is then never asserted.
- READOUT:
  - Frozen; cq ignored.
  - Start index = (count==DEPTH) ? wr_ptr : 0.
  - out_valid=1 with the entry at rd_ptr; buffer read is combinational, so data appears in the same cycle.
  - Handshake out_valid&&out_ready advances rd_ptr (wrapping).
  - out_last=1 on the count-th entry. out_trig=1 when rd_ptr==trig_idx and a trigger entry is flagged.
  - Accepted last entry -> IDLE next cycle, out_valid=0.
  - out_data must hold stable while out_valid && !out_ready.
  - count==0 on entry to READOUT: skip straight to IDLE; out_valid is never asserted.
- abort: highest priority. Next state IDLE from any state and out_valid drops. Buffer contents, count and overflow are retained; a new arm clears them.
- arm outside IDLE: ignored.
- rst mid-operation: behaves exactly as power-on reset.
- Latency: every state transition takes effect one cycle after the causing event.

Optional Feature:
GPU_TRACE_FILTER_EN:
- Defined: cq = retire_valid && wb_en && wb_addr==filter_addr. Only writes to one register are traced.
- Undefined: cq = retire_valid, and filter_addr is ignored.
- PC-match trigger qualification uses cq in both builds.

Decomposition:
- gpu_trace_pkg holds:
  - the state enum (IDLE, ARMED, POST, READOUT)
  - the packed entry struct trace_entry_t
  - a function computing ENTRY_W from the parameters
- Sub-module gpu_trace_ram: DEPTH x ENTRY_W register array, one synchronous write port and one asynchronous read port.

Test Plan:
- Basic capture:
  - Stimulus: arm, 5 retires at pc 1..5, trig_pc_en with trig_pc=3, post_len=2.
  - Required: READOUT with entries pc 1,2,3,4,5; out_trig on pc=3; out_last on pc=5; overflow=0.
- Wrap:
  - Stimulus: DEPTH=16, arm, 20 retires pc 0..19, trig_ext during pc=19, post_len=0.
  - Required: readout pc 4..19 oldest-first; overflow=1; out_last on pc=19.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 during readout.
  - Required: out_data held stable while stalled; no entries lost or duplicated; IDLE one cycle after the last accept.
- Abort and simultaneous events:
  - Stimulus: abort during POST.
  - Required: IDLE next cycle; out_valid never asserted.
  - Stimulus: arm and trig_ext in the same cycle.
  - Required: ARMED, not POST.
  - Stimulus: rst during READOUT.
  - Required: all outputs 0.
- Filter build with GPU_TRACE_FILTER_EN:
  - Stimulus: filter_addr=3; retires write regs 1,3,2,3 with data 0xA,0xB,0xC,0xD.
  - Required: only 0xB and 0xD are captured.
  - Without the macro, all four are captured.
